// File: rtl/uart_arb_defs.sv
// rtl/uart_arb_defs.sv - shared state encodings and frame width helper for the UART frame arbiter
`ifndef UART_ARB_SLICE_W
`define UART_ARB_SLICE_W(nbytes) ((nbytes) * 8)
`endif

package uart_arb_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RELEASE   = 3'd5
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational round-robin pick: first set request at or above ptr, wrapping
module rr_priority_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_oh_o,
    output logic [IDX_W-1:0]   winner_idx_o,
    output logic               valid_o
);

    // One spare bit so ptr + offset never overflows before the explicit wrap.
    logic [IDX_W:0] idx;

    always_comb begin
        winner_oh_o  = '0;
        winner_idx_o = '0;
        valid_o      = 1'b0;
        idx          = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (idx >= (IDX_W + 1)'(NUM_REQ)) begin
                idx = idx - (IDX_W + 1)'(NUM_REQ);
            end
            if (!valid_o && req_i[idx[IDX_W-1:0]]) begin
                valid_o                      = 1'b1;
                winner_oh_o[idx[IDX_W-1:0]] = 1'b1;
                winner_idx_o                 = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin owner of the shared UART transmitter; latches a frame,
// pulses start_tx and tracks tx_busy_total until the frame has been shifted out.
module uart_frame_arbiter
    import uart_arb_defs::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int FRAME_BYTES   = 18,
    parameter int START_TIMEOUT = 1023
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic [NUM_REQ-1:0]                   req_i,
    input  logic [NUM_REQ*FRAME_BYTES*8-1:0]     frame_in_i,
    input  logic                                 tx_busy_total_i,
    output logic [FRAME_BYTES*8-1:0]             frame_out_o,
    output logic                                 start_tx_o,
    output logic [NUM_REQ-1:0]                   grant_o,
    output logic [NUM_REQ-1:0]                   done_o,
    output logic                                 timeout_err_o,
    output logic                                 busy_o
);

    localparam int FRAME_W = `UART_ARB_SLICE_W(FRAME_BYTES);
    localparam int IDX_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = $clog2(START_TIMEOUT + 1);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  to_q, to_d;
    logic [FRAME_W-1:0]    frame_q, frame_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic                  to_hit;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i        (req_i),
        .ptr_i        (rr_ptr_q),
        .winner_oh_o  (pick_oh),
        .winner_idx_o (pick_idx),
        .valid_o      (pick_valid)
    );

    assign to_hit = (state_q == ST_WAIT_BUSY) && !tx_busy_total_i
                    && (cnt_q == CNT_W'(START_TIMEOUT));

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        to_d     = to_q;
        frame_d  = frame_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid && !tx_busy_total_i) begin
                    grant_d = pick_oh;
                    owner_d = pick_idx;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (owner_q == IDX_W'(i)) begin
                        frame_d = frame_in_i[i*FRAME_W +: FRAME_W];
                    end
                end
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                to_d    = 1'b0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_total_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_hit) begin
                    to_d    = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_total_i) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Advance past the owner even after a timeout so a dead producer cannot starve others.
                rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                grant_d  = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            to_q     <= 1'b0;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            to_q     <= to_d;
            frame_q  <= frame_d;
        end
    end

    assign frame_out_o   = frame_q;
    assign grant_o       = grant_q;
    assign start_tx_o    = (state_q == ST_START);
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_RELEASE && !to_q) ? grant_q : '0;
    assign timeout_err_o = to_hit;

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Shares the single UART transmitter (`uart_controller`, `tx_busy_total` handshake) among several frame producers (hex-debug dump, I2C sensor readout, CPU register dump). It accepts level requests, grants one requester at a time in round-robin order, and latches that requester's frame onto the transmitter's `data_to_send`. It then pulses `start_tx` and tracks `tx_busy_total` until the frame is fully shifted out, and acknowledges the requester with a one-cycle `done`. It sits between the producers and `uart_controller` in the top level, replacing the direct button-to-`start_tx` connection.

## Interface
- `NUM_REQ`, 3: number of requesters (2..8).
- `FRAME_BYTES`, 18: bytes per frame; must equal the `uart_controller` `BYTES`.
- `START_TIMEOUT`, 1023: maximum cycles to wait for `tx_busy_total` to rise after `start_tx`.
- `clk` in 1: system clock; single clock domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: level request per producer; must be held until that producer's `done` or `timeout_err`.
- `frame_in` in NUM_REQ*FRAME_BYTES*8: flattened frames; requester i occupies bits [(i+1)*FRAME_BYTES*8-1 : i*FRAME_BYTES*8].
- `tx_busy_total` in 1: transmitter busy, from `uart_controller`.
- `frame_out` out FRAME_BYTES*8: latched frame, drives `data_to_send`.
- `start_tx` out 1: one-cycle start pulse to `uart_controller`.
- `grant` out NUM_REQ: one-hot owner; all zero when idle.
- `done` out NUM_REQ: one-cycle pulse on the owner's bit when its frame has completed.
- `timeout_err` out 1: one-cycle pulse when the transmitter never went busy.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, RELEASE.
- IDLE:
  - If `req` != 0 and `tx_busy_total` = 0, select a winner: the first set bit scanning upward from `rr_ptr`, wrapping at NUM_REQ.
  - Register `grant` and go to LOAD.
  - If `tx_busy_total` = 1 (the transmitter is in use elsewhere), stay in IDLE.
- LOAD: latch `frame_out` from the winner's `frame_in` slice, then go to START. `frame_out` is frozen from this point until the next LOAD.
- START: assert `start_tx` for exactly this cycle, clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_busy_total` = 1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter equals START_TIMEOUT, pulse `timeout_err` and go to RELEASE with no `done`.
- WAIT_DONE: when `tx_busy_total` = 0, go to RELEASE. There is no timeout in this state.
- RELEASE:
  - Pulse `done[owner]`, unless the transfer ended in timeout.
  - Set `rr_ptr` = (owner+1) mod NUM_REQ, clear `grant`, return to IDLE.
  - The pointer advances on timeout as well, so a dead requester cannot starve the others.
- A requester that deasserts `req` while granted does not abort the transfer; it completes and `done` is still pulsed.
- `req` bits at index ≥ NUM_REQ do not exist.
- `rr_ptr` is a log2(NUM_REQ)-bit register; wrap from NUM_REQ-1 to 0 is explicit, not a power-of-two overflow.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State IDLE, `rr_ptr` = 0.
  - `grant`, `done`, `start_tx`, `timeout_err`, `busy` all = 0.
  - `frame_out` = 0.
- Reset asserted mid-transfer: outputs clear immediately. No `done` is produced. The `uart_controller` is reset by the same net.
- Request seen in IDLE at cycle t:
  - `grant` and `busy` high at t+1.
  - `frame_out` valid at t+2.
  - `start_tx` high during t+2, so `frame_out` is stable in the same cycle `start_tx` is sampled.
- `tx_busy_total` falling at cycle u: `done` high at u+1 (RELEASE).
- `grant` low at u+2; a new grant is possible at u+3.
- Minimum spacing between two `start_tx` pulses: 5 cycles plus transmission time.
- When a new request arrives in the same cycle as RELEASE, it is arbitrated in the following IDLE cycle using the updated `rr_ptr`.

## Structure
- Shared package/header `uart_arb_defs`: state encodings (3-bit localparams), and the frame-slice width macro used by both this block and the top level.
- One sub-module, `rr_priority_pick`: combinational, takes `req` and `rr_ptr`, returns a one-hot winner and its index.
- The FSM, frame latch, and timeout counter live in `uart_frame_arbiter`.

## Test plan
- **Single request:** NUM_REQ=3, `req`=3'b010, busy model rises 2 cycles after `start_tx` and lasts 50 cycles.
  - One `start_tx` with `frame_out` = slice 1.
  - `done` = 3'b010 exactly once.
  - `grant` = 3'b010 throughout.
- **Round robin:** `req`=3'b111 held continuously → grant order 0, 1, 2, 0, with exactly one `done` per grant.
- **Busy at request:** `tx_busy_total` held high 20 cycles before `req`=3'b001.
  - No `start_tx` until busy falls.
  - `start_tx` 2 cycles after the first idle arbitration.
- **Timeout:** START_TIMEOUT=15, busy never rises after `req`=3'b100.
  - `timeout_err` pulses 16 cycles after `start_tx`.
  - `done` stays 0.
  - Next grant goes to requester 0.
- **Reset mid-transfer:** `reset_n` pulled low during WAIT_DONE.
  - All outputs 0 in the same cycle.
  - After release, `req`=3'b011 grants requester 0 first.
- **Request drop:** owner deasserts `req` during WAIT_DONE → transfer still completes and `done` is still pulsed.
